arb4: RTL and testbench

Four-way round-robin bus arbiter that generates the 2-bit select and one-hot grant driving the shared `WIDTH`-bit request multiplexer, and routes the shared target's completion and read data back to the granted requester. It sits between up to four bus initiators (e.g. instruction fetch, load/store, debug, DMA) and a single shared memory/peripheral port, owning the select side of the 4:1 request mux and the 1:4 response demux.

---
 rtl/arb4.sv | 98 +++++++++
 tb/tb_arb4.sv | 176 +++++++++++++++++
 2 files changed

// File: rtl/arb4.sv
// arb4: four-way round-robin bus arbiter.
//
// Owns the select side of a shared 4:1 request mux and the 1:4 response demux
// between up to four bus initiators and a single shared target port.
//
// Parameters
//   WIDTH    width of the response data path
// Ports
//   i_clk    clock, all state changes on the rising edge
//   i_rst    synchronous active-high reset
//   i_req    per-initiator request, held until the matching o_ack bit
//   i_ack    shared target completion, single-cycle pulse
//   i_rdata  shared target read data, valid with i_ack
//   o_sel    registered index of the current owner (request mux select)
//   o_gnt    registered one-hot grant, zero when idle
//   o_busy   registered, high while a grant is active
//   o_ack    one-hot completion to the owner, combinational with i_ack
//   o_rdata  i_rdata while busy, else zero
module arb4 #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [3:0]       i_req,
  input  logic             i_ack,
  input  logic [WIDTH-1:0] i_rdata,
  output logic [1:0]       o_sel,
  output logic [3:0]       o_gnt,
  output logic             o_busy,
  output logic [3:0]       o_ack,
  output logic [WIDTH-1:0] o_rdata
);

  typedef enum logic [0:0] {StIdle, StGrant} state_e;

  state_e     state_q;
  logic [1:0] sel_q;
  logic [3:0] gnt_q;
  logic       busy_q;
  logic [1:0] last_q;
  logic [1:0] winner;
  logic       found;

  // Round-robin scan starting just after the most recent owner; the
  // 2-bit sum wraps so the previous owner is examined last.
  always_comb begin
    winner = last_q + 2'd1;
    found  = 1'b0;
    for (int unsigned i = 1; i <= 4; i++) begin
      if (!found && i_req[last_q + 2'(i)]) begin
        winner = last_q + 2'(i);
        found  = 1'b1;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= StIdle;
      sel_q   <= 2'd0;
      gnt_q   <= 4'b0000;
      busy_q  <= 1'b0;
      last_q  <= 2'd3;  // initiator 0 wins first after reset
    end else begin
      case (state_q)
        StIdle: begin
          // i_ack seen here has no owner and is dropped.
          if (|i_req) begin
            state_q <= StGrant;
            sel_q   <= winner;
            gnt_q   <= 4'b0001 << winner;
            busy_q  <= 1'b1;
          end
        end
        StGrant: begin
          // Completion and abort both release; sel_q is left unchanged so the
          // mux select stays stable through the release edge.
          if (i_ack || !i_req[sel_q]) begin
            state_q <= StIdle;
            gnt_q   <= 4'b0000;
            busy_q  <= 1'b0;
            last_q  <= sel_q;
          end
        end
        default: begin
          state_q <= StIdle;
        end
      endcase
    end
  end

  assign o_sel   = sel_q;
  assign o_gnt   = gnt_q;
  assign o_busy  = busy_q;
  assign o_ack   = {4{i_ack}} & gnt_q;
  assign o_rdata = busy_q ? i_rdata : '0;

endmodule

// File: tb/tb_arb4.sv
// Directed testbench for arb4. Inputs are driven and outputs sampled on the
// falling clock edge, well away from the active rising edge.
module tb_arb4;

  logic        clk;
  logic        rst;
  logic [3:0]  req;
  logic        ack;
  logic [31:0] rdata;
  logic [1:0]  sel;
  logic [3:0]  gnt;
  logic        busy;
  logic [3:0]  ack_o;
  logic [31:0] rdata_o;

  int n_tests = 0;
  int n_fail  = 0;

  arb4 #(.WIDTH(32)) dut (
    .i_clk   (clk),
    .i_rst   (rst),
    .i_req   (req),
    .i_ack   (ack),
    .i_rdata (rdata),
    .o_sel   (sel),
    .o_gnt   (gnt),
    .o_busy  (busy),
    .o_ack   (ack_o),
    .o_rdata (rdata_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Check the registered grant outputs together.
  task automatic check_grant(input string tag, input logic [1:0] e_sel, input logic [3:0] e_gnt,
                             input logic e_busy);
    check({tag, ".sel"}, 32'(sel), 32'(e_sel));
    check({tag, ".gnt"}, 32'(gnt), 32'(e_gnt));
    check({tag, ".busy"}, 32'(busy), 32'(e_busy));
  endtask

  logic [1:0] order [5] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0};
  logic [3:0] toggles [5] = '{4'b1111, 4'b0101, 4'b1110, 4'b0100, 4'b1101};

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    ack   = 1'b0;
    rdata = 32'h0;
    @(negedge clk);
    @(negedge clk);

    // Reset state
    rst = 1'b0;
    check_grant("reset", 2'd0, 4'b0000, 1'b0);
    check("reset.ack", 32'(ack_o), 32'h0);
    check("reset.rdata", rdata_o, 32'h0);

    // All four requesting: strict rotation 0,1,2,3,0 with one idle cycle between
    req = 4'b1111;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check_grant($sformatf("rr%0d.grant", k), order[k], 4'b0001 << order[k], 1'b1);
      @(negedge clk);
      check_grant($sformatf("rr%0d.hold", k), order[k], 4'b0001 << order[k], 1'b1);
      ack = 1'b1;
      #1;
      check($sformatf("rr%0d.ack", k), 32'(ack_o), 32'(4'b0001 << order[k]));
      @(negedge clk);
      ack = 1'b0;
      check_grant($sformatf("rr%0d.idle", k), order[k], 4'b0000, 1'b0);
      if (k == 4) req = 4'b0000;
    end

    // Single requester 2 with read data; last owner is 0
    req   = 4'b0100;
    rdata = 32'hDEADBEEF;
    @(negedge clk);
    check_grant("single.grant", 2'd2, 4'b0100, 1'b1);
    @(negedge clk);
    @(negedge clk);
    ack = 1'b1;
    #1;
    check("single.ack", 32'(ack_o), 32'h4);
    check("single.rdata", rdata_o, 32'hDEADBEEF);
    @(negedge clk);
    ack = 1'b0;
    req = 4'b0000;
    check_grant("single.release", 2'd2, 4'b0000, 1'b0);
    check("single.rdata_idle", rdata_o, 32'h0);

    // Ack while idle is discarded
    ack   = 1'b1;
    rdata = 32'h12345678;
    #1;
    check("idle_ack.ack", 32'(ack_o), 32'h0);
    check("idle_ack.rdata", rdata_o, 32'h0);
    @(negedge clk);
    ack = 1'b0;
    check_grant("idle_ack.state", 2'd2, 4'b0000, 1'b0);

    // Abort: owner 1 (last=2, scan 3,0,1) drops its request
    req = 4'b0010;
    @(negedge clk);
    check_grant("abort.grant", 2'd1, 4'b0010, 1'b1);
    req = 4'b0001;
    #1;
    check("abort.no_ack", 32'(ack_o), 32'h0);
    @(negedge clk);
    check_grant("abort.idle", 2'd1, 4'b0000, 1'b0);
    check("abort.idle_ack", 32'(ack_o), 32'h0);
    req = 4'b0011;
    @(negedge clk);
    check_grant("abort.wrap", 2'd0, 4'b0001, 1'b1);
    ack = 1'b1;
    #1;
    check("abort.wrap_ack", 32'(ack_o), 32'h1);
    @(negedge clk);
    ack = 1'b0;
    req = 4'b0000;
    check_grant("abort.release", 2'd0, 4'b0000, 1'b0);

    // Reset mid-grant: owner 3 (last=0, scan 1,2,3)
    req = 4'b1000;
    @(negedge clk);
    check_grant("rst.grant", 2'd3, 4'b1000, 1'b1);
    rst = 1'b1;
    ack = 1'b1;
    req = 4'b1001;
    #1;
    check("rst.pending_ack", 32'(ack_o), 32'h8);
    @(negedge clk);
    rst = 1'b0;
    ack = 1'b0;
    check_grant("rst.cleared", 2'd0, 4'b0000, 1'b0);
    @(negedge clk);
    check_grant("rst.first", 2'd0, 4'b0001, 1'b1);
    ack = 1'b1;
    #1;
    check("rst.first_ack", 32'(ack_o), 32'h1);
    @(negedge clk);
    ack = 1'b0;
    req = 4'b0000;

    // Owner 2 (last=0, scan 1,2) with other request bits toggling
    req = 4'b0100;
    @(negedge clk);
    check_grant("hold.grant", 2'd2, 4'b0100, 1'b1);
    for (int k = 0; k < 5; k++) begin
      req = toggles[k];
      @(negedge clk);
      check_grant($sformatf("hold%0d", k), 2'd2, 4'b0100, 1'b1);
    end
    ack = 1'b1;
    #1;
    check("hold.ack", 32'(ack_o), 32'h4);
    check("hold.sel_at_ack", 32'(sel), 32'h2);
    @(negedge clk);
    ack = 1'b0;
    req = 4'b0000;
    check_grant("hold.release", 2'd2, 4'b0000, 1'b0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
